// File: rtl/nv_nvdla_conv_seq_if.sv
// Sequencer handshake bundle: descriptor intake, CSC strobes, CACC->SDP
// completion observation and status.
interface nv_nvdla_conv_seq_if #(
    parameter int CNT_W = 16,
    parameter int CRD_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_atoms;
    logic [CNT_W-1:0] cfg_stripes;
    logic             abort;
    logic             weight_i_valid;
    logic             data_i_valid;
    logic             cacc2sdp_valid;
    logic             sdp2cacc_ready;
    logic [CRD_W-1:0] in_flight;
    logic             busy;
    logic             done_irq;
    logic             err_underflow;

    modport master (
        output cfg_valid, cfg_atoms, cfg_stripes, abort,
               cacc2sdp_valid, sdp2cacc_ready,
        input  cfg_ready, weight_i_valid, data_i_valid,
               in_flight, busy, done_irq, err_underflow
    );

    modport slave (
        input  cfg_valid, cfg_atoms, cfg_stripes, abort,
               cacc2sdp_valid, sdp2cacc_ready,
        output cfg_ready, weight_i_valid, data_i_valid,
               in_flight, busy, done_irq, err_underflow
    );
endinterface

// File: rtl/nv_nvdla_conv_seq.sv
// Convolution layer sequencer: issues weight/data strobes to CSC per stripe
// and atom, throttled by a credit count of atoms not yet retired to SDP.
module nv_nvdla_conv_seq #(
    parameter int CNT_W      = 16,
    parameter int CREDIT_MAX = 8,
    parameter int CRD_W      = $clog2(CREDIT_MAX + 1)
) (
    input logic                nvdla_core_clk,
    input logic                nvdla_core_rst,
    nv_nvdla_conv_seq_if.slave seq
);

    typedef enum logic [2:0] {IDLE, WT, DATA, DRAIN, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] atoms_q;
    logic [CNT_W-1:0] stripes_q;
    logic [CNT_W-1:0] atom_cnt_q;
    logic [CNT_W-1:0] stripe_cnt_q;
    logic [CRD_W-1:0] in_flight_q;
    logic             err_q;

    logic cfg_fire;
    logic data_fire;
    logic comp;
    logic abort_hit;
    logic atom_last;
    logic stripe_last;

    assign cfg_fire    = (state_q == IDLE) && seq.cfg_valid;
    assign data_fire   = (state_q == DATA) && (in_flight_q < CRD_W'(CREDIT_MAX));
    assign comp        = seq.cacc2sdp_valid && seq.sdp2cacc_ready;
    assign abort_hit   = seq.abort && (state_q != IDLE);
    assign atom_last   = (atom_cnt_q == atoms_q - CNT_W'(1));
    assign stripe_last = (stripe_cnt_q == stripes_q - CNT_W'(1));

    // Descriptor sizes are only meaningful once a layer is accepted.
    always_ff @(posedge nvdla_core_clk) begin
        if (cfg_fire) begin
            atoms_q   <= seq.cfg_atoms;
            stripes_q <= seq.cfg_stripes;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q      <= IDLE;
            atom_cnt_q   <= '0;
            stripe_cnt_q <= '0;
        end else if (abort_hit) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seq.cfg_valid) begin
                        atom_cnt_q   <= '0;
                        stripe_cnt_q <= '0;
                        state_q      <= ((seq.cfg_atoms == '0) || (seq.cfg_stripes == '0)) ? DONE : WT;
                    end
                end
                WT: state_q <= DATA;
                DATA: begin
                    if (data_fire) begin
                        if (atom_last) begin
                            atom_cnt_q <= '0;
                            if (stripe_last) begin
                                state_q <= DRAIN;
                            end else begin
                                stripe_cnt_q <= stripe_cnt_q + CNT_W'(1);
                                state_q      <= WT;
                            end
                        end else begin
                            atom_cnt_q <= atom_cnt_q + CNT_W'(1);
                        end
                    end
                end
                DRAIN: if (in_flight_q == '0) state_q <= DONE;
                DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completions are tracked in every state; a strobe and a completion in
    // the same cycle cancel out.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            in_flight_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (comp && (in_flight_q == '0)) err_q <= 1'b1;
            if (abort_hit) begin
                in_flight_q <= '0;
            end else if (data_fire && !comp) begin
                in_flight_q <= in_flight_q + CRD_W'(1);
            end else if (comp && !data_fire && (in_flight_q != '0)) begin
                in_flight_q <= in_flight_q - CRD_W'(1);
            end
        end
    end

    assign seq.cfg_ready      = (state_q == IDLE);
    assign seq.busy           = (state_q != IDLE);
    assign seq.weight_i_valid = (state_q == WT);
    assign seq.data_i_valid   = data_fire;
    assign seq.done_irq       = (state_q == DONE);
    assign seq.in_flight      = in_flight_q;
    assign seq.err_underflow  = err_q;

endmodule

// File: tb/tb_nv_nvdla_conv_seq.sv
// Scoreboard bench for nv_nvdla_conv_seq: CACC return model, credit model and
// expected strobe/interrupt cycle queues.
module tb_nv_nvdla_conv_seq;
    localparam int CNT_W      = 16;
    localparam int CREDIT_MAX = 8;
    localparam int CRD_W      = $clog2(CREDIT_MAX + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nv_nvdla_conv_seq_if #(.CNT_W(CNT_W), .CRD_W(CRD_W)) sif ();

    nv_nvdla_conv_seq #(.CNT_W(CNT_W), .CREDIT_MAX(CREDIT_MAX), .CRD_W(CRD_W)) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .seq(sif)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controls written only by the main sequence
    bit run      = 0;
    bit exact    = 0;
    int rdy_mode = 1;   // 0: ready low, 1: ready high, 2: random
    int lat      = 5;
    int spur_req = 0;
    int exp_wt[$];
    int exp_dat[$];
    int exp_irq[$];

    // State written only by the monitor
    int spur_done = 0;
    int m_if      = 0;
    bit m_err     = 0;
    int ret[$];
    int n_wt = 0, n_dat = 0, n_irq = 0, n_both = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: checks outputs of the current cycle, then drives the CACC/SDP
    // side for this cycle and advances the credit model.
    initial begin
        bit strobe, real_c, cv, rd, comp;
        sif.cacc2sdp_valid = 1'b0;
        sif.sdp2cacc_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (run) begin
                strobe = sif.data_i_valid;
                check("in_flight", sif.in_flight, m_if);
                check("err_underflow", sif.err_underflow, m_err);
                if (sif.weight_i_valid) begin
                    n_wt++;
                    if (exp_wt.size() > 0) check("wt_cycle", cyc, exp_wt.pop_front());
                    else if (exact) check("wt_extra", 1, 0);
                end
                if (strobe) begin
                    n_dat++;
                    check("credit_gate", m_if < CREDIT_MAX, 1);
                    if (exp_dat.size() > 0) check("dat_cycle", cyc, exp_dat.pop_front());
                    else if (exact) check("dat_extra", 1, 0);
                end
                if (sif.done_irq) begin
                    n_irq++;
                    if (exp_irq.size() > 0) check("irq_cycle", cyc, exp_irq.pop_front());
                    else if (exact) check("irq_extra", 1, 0);
                end
                real_c = (ret.size() > 0) && (ret[0] <= cyc);
                cv = real_c || (spur_req != spur_done);
                case (rdy_mode)
                    0:       rd = 1'b0;
                    1:       rd = 1'b1;
                    default: rd = 1'($urandom_range(0, 1));
                endcase
                if (spur_req != spur_done) begin
                    rd = 1'b1;
                    spur_done++;
                end
                comp = cv && rd;
                sif.cacc2sdp_valid = cv;
                sif.sdp2cacc_ready = rd;
                if (comp && m_if == 0) m_err = 1'b1;
                if (comp && real_c) void'(ret.pop_front());
                if (strobe) ret.push_back(cyc + lat);
                if (strobe && comp) n_both++;
                if (rst) begin
                    m_if = 0;
                    m_err = 1'b0;
                    ret.delete();
                end else if (sif.abort) begin
                    m_if = 0;
                    ret.delete();
                end else if (strobe && !comp) begin
                    m_if++;
                end else if (comp && !strobe && m_if > 0) begin
                    m_if--;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        while (cyc < n) step(1);
    endtask

    // Drives a descriptor in the current cycle; returns in the next cycle.
    task automatic load_cfg(input int a, input int s);
        check("cfg_ready_pre", sif.cfg_ready, 1);
        sif.cfg_valid   = 1'b1;
        sif.cfg_atoms   = CNT_W'(a);
        sif.cfg_stripes = CNT_W'(s);
        step(1);
        sif.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!sif.busy) return;
            step(1);
        end
        check("idle_timeout", sif.busy, 0);
    endtask

    task automatic check_queues(input string tag);
        check(tag, exp_wt.size() + exp_dat.size() + exp_irq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, r0, bw, bd, bi;
        sif.cfg_valid   = 1'b0;
        sif.cfg_atoms   = '0;
        sif.cfg_stripes = '0;
        sif.abort       = 1'b0;

        // Reset state
        rst = 1'b1;
        step(3);
        check("rst_cfg_ready", sif.cfg_ready, 1);
        check("rst_busy", sif.busy, 0);
        check("rst_wt", sif.weight_i_valid, 0);
        check("rst_dat", sif.data_i_valid, 0);
        check("rst_irq", sif.done_irq, 0);
        check("rst_in_flight", sif.in_flight, 0);
        check("rst_err", sif.err_underflow, 0);
        rst = 1'b0;
        run = 1'b1;

        // Nominal layer: 2 stripes x 4 atoms, results return 5 cycles after issue
        step(1);
        exact = 1; rdy_mode = 1; lat = 5;
        t0 = cyc;
        exp_wt.push_back(t0 + 1); exp_wt.push_back(t0 + 6);
        for (int i = 2; i <= 5; i++) exp_dat.push_back(t0 + i);
        for (int i = 7; i <= 10; i++) exp_dat.push_back(t0 + i);
        exp_irq.push_back(t0 + 17);
        bi = n_irq;
        load_cfg(4, 2);
        go(t0 + 17);
        check("t1_busy_done", sif.busy, 1);
        go(t0 + 18);
        check("t1_busy_drop", sif.busy, 0);
        check("t1_cfg_ready", sif.cfg_ready, 1);
        step(2);
        check_queues("t1_queues");
        check("t1_irq_count", n_irq - bi, 1);

        // Credit backpressure
        exact = 0; rdy_mode = 0;
        step(1);
        t0 = cyc; bd = n_dat; bi = n_irq;
        load_cfg(12, 1);
        go(t0 + 20);
        check("bp_stall_count", n_dat - bd, CREDIT_MAX);
        check("bp_stall_if", sif.in_flight, CREDIT_MAX);
        check("bp_stall_dat", sif.data_i_valid, 0);
        rdy_mode = 1;
        r0 = cyc;
        go(r0 + 3);
        check("bp_resume_dat", sif.data_i_valid, 1);
        check("bp_resume_if", sif.in_flight, CREDIT_MAX - 1);
        go(r0 + 5);
        check("bp_total", n_dat - bd, 12);
        wait_idle(100);
        check("bp_irq", n_irq - bi, 1);

        // Random ready: 5 stripes x 100 atoms, strobes and completions overlap
        rdy_mode = 2; lat = 3;
        step(1);
        bw = n_wt; bd = n_dat; bi = n_irq; r0 = n_both;
        load_cfg(100, 5);
        wait_idle(4000);
        check("rnd_dat_total", n_dat - bd, 500);
        check("rnd_wt_total", n_wt - bw, 5);
        check("rnd_irq", n_irq - bi, 1);
        check("rnd_overlap_seen", (n_both - r0) > 0, 1);

        // Zero-size descriptor
        rdy_mode = 1; lat = 5; exact = 1;
        step(2);
        t0 = cyc;
        exp_irq.push_back(t0 + 1);
        load_cfg(0, 3);
        check("zero_cfg_ready_c1", sif.cfg_ready, 0);
        step(1);
        check("zero_cfg_ready_c2", sif.cfg_ready, 1);
        check("zero_busy_c2", sif.busy, 0);
        step(1);
        check_queues("zero_queues");

        // Abort after 3 of 10 atoms, then a fresh layer in the next cycle
        lat = 20;
        t0 = cyc;
        exp_wt.push_back(t0 + 1);
        for (int i = 2; i <= 4; i++) exp_dat.push_back(t0 + i);
        load_cfg(10, 1);
        go(t0 + 4);
        sif.abort = 1'b1;
        step(1);
        sif.abort = 1'b0;
        check("abort_busy", sif.busy, 0);
        check("abort_cfg_ready", sif.cfg_ready, 1);
        check("abort_in_flight", sif.in_flight, 0);
        check("abort_dat", sif.data_i_valid, 0);
        lat = 5;
        t0 = cyc;
        exp_wt.push_back(t0 + 1); exp_wt.push_back(t0 + 4);
        exp_dat.push_back(t0 + 2); exp_dat.push_back(t0 + 3);
        exp_dat.push_back(t0 + 5); exp_dat.push_back(t0 + 6);
        exp_irq.push_back(t0 + 13);
        load_cfg(2, 2);
        wait_idle(60);
        step(2);
        check_queues("abort_queues");

        // Spurious completion in IDLE, then reset in mid-layer
        spur_req++;
        step(1);
        step(1);
        check("spur_err", sif.err_underflow, 1);
        step(3);
        check("spur_err_held", sif.err_underflow, 1);
        check("spur_in_flight", sif.in_flight, 0);
        t0 = cyc;
        exp_wt.push_back(t0 + 1);
        for (int i = 2; i <= 4; i++) exp_dat.push_back(t0 + i);
        load_cfg(6, 1);
        go(t0 + 4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_busy", sif.busy, 0);
        check("mrst_cfg_ready", sif.cfg_ready, 1);
        check("mrst_in_flight", sif.in_flight, 0);
        check("mrst_err", sif.err_underflow, 0);
        check("mrst_dat", sif.data_i_valid, 0);
        step(3);
        check_queues("mrst_queues");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
